// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
//
// Receive-side checker for the 4-road lamp vector driven by the traffic light
// controller. Samples `light` every clock, tracks the active road and phase,
// times green/yellow/all-red durations, enforces round-robin road order
// (0->1->2->3->0) and latches the first violation as a sticky fault.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset (also clears a latched fault)
//   light[11:0]  road k lamps at light[3k+2:3k] = {red, yellow, green}
//   active_road  road holding green/yellow (last granted road during all-red)
//   phase        0=SYNC, 1=GREEN, 2=YELLOW, 3=ALLRED (frozen once faulted)
//   cycle_done   one-cycle pulse when road 3 leaves yellow legally
//   fault        sticky violation flag
//   fault_code   1 ENCODING, 2 CONFLICT, 3 SEQUENCE, 4 GREEN_TIME,
//                5 YELLOW_TIME, 6 STALL (0 = none)
//   cycle_cnt    completed rotations
//
// Build option: define TLM_CYCLE_COUNT_EN to enable the saturating rotation
// counter on cycle_cnt; otherwise cycle_cnt is tied to zero.
// -----------------------------------------------------------------------------
module traffic_light_monitor #(
  parameter int GREEN_CYC  = 20,
  parameter int YELLOW_CYC = 5,
  parameter int ALLRED_MAX = 2,
  parameter int SYNC_MAX   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] light,
  output logic [1:0]  active_road,
  output logic [1:0]  phase,
  output logic        cycle_done,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [15:0] cycle_cnt
);

  typedef enum logic [2:0] {ST_SYNC, ST_GREEN, ST_YELLOW, ST_ALLRED, ST_FAULT} state_t;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_ENCODING = 3'd1;
  localparam logic [2:0] FC_CONFLICT = 3'd2;
  localparam logic [2:0] FC_SEQUENCE = 3'd3;
  localparam logic [2:0] FC_GREEN_T  = 3'd4;
  localparam logic [2:0] FC_YELLOW_T = 3'd5;
  localparam logic [2:0] FC_STALL    = 3'd6;

  localparam logic [7:0] GREEN_LIM  = 8'(GREEN_CYC);
  localparam logic [7:0] YELLOW_LIM = 8'(YELLOW_CYC);
  localparam logic [7:0] ALLRED_LIM = 8'(ALLRED_MAX);
  localparam logic [7:0] SYNC_LIM   = 8'(SYNC_MAX);

  state_t      state_q, state_d;
  logic [1:0]  road_d, phase_d, grn_idx, nxt_road;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;   // one duration counter shared by all phases
  logic        first_q, first_d;        // first green after sync may be short
  logic [2:0]  code_d;
  logic        done_d;
  logic [3:0]  red, yel, grn, lamp_ok, nonred;
  logic        enc_err, conf_err, all_red;
  logic        err_seq, err_gt, err_yt, err_stall, legal_exit;

  // Lamp decode
  always_comb begin
    red = '0; yel = '0; grn = '0; lamp_ok = '0;
    for (int k = 0; k < 4; k++) begin
      red[k]     = light[3*k+2];
      yel[k]     = light[3*k+1];
      grn[k]     = light[3*k];
      lamp_ok[k] = (light[3*k +: 3] == 3'b100) || (light[3*k +: 3] == 3'b010) ||
                   (light[3*k +: 3] == 3'b001);
    end
  end

  always_comb begin
    grn_idx = '0;
    for (int k = 0; k < 4; k++) if (grn[k]) grn_idx = 2'(k);
  end

  assign nonred   = ~red;
  assign enc_err  = ~&lamp_ok;
  assign conf_err = (nonred & (nonred - 4'd1)) != 4'd0;   // more than one bit set
  assign all_red  = &red;
  assign nxt_road = active_road + 2'd1;                   // wraps 3 -> 0
  assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // Next-state and check logic. With no ENCODING/CONFLICT error at most one
  // road is non-red, so "active road green" implies all others are red.
  // NOTE: every combinational output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    road_d     = active_road;
    cnt_d      = cnt_q;
    first_d    = first_q;
    err_seq    = 1'b0;
    err_gt     = 1'b0;
    err_yt     = 1'b0;
    err_stall  = 1'b0;
    legal_exit = 1'b0;
    code_d     = FC_NONE;
    done_d     = 1'b0;
    phase_d    = phase;

    unique case (state_q)
      ST_SYNC: begin
        if (|grn) begin
          state_d = ST_GREEN; road_d = grn_idx; cnt_d = 8'd1; first_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc > SYNC_LIM) err_stall = 1'b1;
        end
      end
      ST_GREEN: begin
        if (grn[active_road]) begin
          cnt_d = cnt_inc;
          if (cnt_inc > GREEN_LIM) err_gt = 1'b1;
        end else if (yel[active_road]) begin
          if (cnt_q != GREEN_LIM && !first_q) err_gt = 1'b1;
          else begin
            state_d = ST_YELLOW; cnt_d = 8'd1; first_d = 1'b0;
          end
        end else begin
          err_seq = 1'b1;
        end
      end
      ST_YELLOW: begin
        if (yel[active_road]) begin
          cnt_d = cnt_inc;
          if (cnt_inc > YELLOW_LIM) err_yt = 1'b1;
        end else if (grn[active_road]) begin
          err_seq = 1'b1;
        end else if (all_red || grn[nxt_road]) begin
          if (cnt_q != YELLOW_LIM) err_yt = 1'b1;
          else begin
            legal_exit = 1'b1;
            cnt_d      = 8'd1;
            if (all_red) state_d = ST_ALLRED;
            else begin
              state_d = ST_GREEN; road_d = nxt_road;
            end
          end
        end else begin
          err_seq = 1'b1;   // wrong road green, or another road yellow
        end
      end
      ST_ALLRED: begin
        if (all_red) begin
          cnt_d = cnt_inc;
          if (cnt_inc > ALLRED_LIM) err_stall = 1'b1;
        end else if (grn[nxt_road]) begin
          state_d = ST_GREEN; road_d = nxt_road; cnt_d = 8'd1;
        end else begin
          err_seq = 1'b1;
        end
      end
      default: ;            // ST_FAULT: everything holds, no checks
    endcase

    if (state_q != ST_FAULT) begin
      if      (enc_err)   code_d = FC_ENCODING;
      else if (conf_err)  code_d = FC_CONFLICT;
      else if (err_seq)   code_d = FC_SEQUENCE;
      else if (err_gt)    code_d = FC_GREEN_T;
      else if (err_yt)    code_d = FC_YELLOW_T;
      else if (err_stall) code_d = FC_STALL;
    end

    if (code_d != FC_NONE) begin
      state_d = ST_FAULT; road_d = active_road; cnt_d = cnt_q; first_d = first_q;
    end else begin
      done_d = legal_exit && (active_road == 2'd3);
    end

    unique case (state_d)
      ST_SYNC:   phase_d = 2'd0;
      ST_GREEN:  phase_d = 2'd1;
      ST_YELLOW: phase_d = 2'd2;
      ST_ALLRED: phase_d = 2'd3;
      default:   phase_d = phase;   // frozen while faulted
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      active_road <= '0;
      phase       <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      cycle_done  <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
    end else begin
      state_q     <= state_d;
      active_road <= road_d;
      phase       <= phase_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      cycle_done  <= done_d;
      if (code_d != FC_NONE) begin
        fault      <= 1'b1;
        fault_code <= code_d;
      end
    end
  end

`ifdef TLM_CYCLE_COUNT_EN
  // Counts on the same edge that raises cycle_done; done_d is never set while
  // faulted, so the count freezes in FAULT.
  always_ff @(posedge clk) begin
    if (rst)                                cycle_cnt <= '0;
    else if (done_d && cycle_cnt != 16'hFFFF) cycle_cnt <= cycle_cnt + 16'd1;
  end
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_monitor
//
// Self-checking bench for traffic_light_monitor with default parameters.
// A table of {light, repeat count, expected outputs} records drives two legal
// rotations, a zero-gap handover and a short-green fault; hand-written
// sequences cover reset, each fault code, resync and the SYNC timeout.
// Outputs are sampled 1 time unit after the rising edge that captured light.
// -----------------------------------------------------------------------------
module tb_traffic_light_monitor;

  localparam logic [11:0] ALLRED = 12'b100_100_100_100;
  localparam logic [2:0]  LY     = 3'b010;
  localparam logic [2:0]  LG     = 3'b001;
`ifdef TLM_CYCLE_COUNT_EN
  localparam logic [15:0] ROT_EXP = 16'd2;
  localparam logic [15:0] ONE_EXP = 16'd1;
`else
  localparam logic [15:0] ROT_EXP = 16'd0;
  localparam logic [15:0] ONE_EXP = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] light = ALLRED;
  logic [1:0]  active_road, phase;
  logic        cycle_done, fault;
  logic [2:0]  fault_code;
  logic [15:0] cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  typedef struct {
    logic [11:0] light;
    int          reps;
    logic [1:0]  phase;
    logic [1:0]  road;
    logic        done;
    logic        fault;
    logic [2:0]  code;
  } vec_t;

  vec_t tbl[$];

  traffic_light_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .light       (light),
    .active_road (active_road),
    .phase       (phase),
    .cycle_done  (cycle_done),
    .fault       (fault),
    .fault_code  (fault_code),
    .cycle_cnt   (cycle_cnt)
  );

  always #5 clk = ~clk;

  // All roads red except `road`, which shows `lamp`.
  function automatic logic [11:0] lv(input int road, input logic [2:0] lamp);
    logic [11:0] v;
    v = ALLRED;
    v[3*road +: 3] = lamp;
    return v;
  endfunction

  task automatic step(input logic [11:0] v);
    light = v;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input logic [11:0] v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic f, input logic [2:0] c,
                           input logic [1:0] p, input logic [1:0] r);
    check({tag, " fault"},       16'(fault),       16'(f));
    check({tag, " fault_code"},  16'(fault_code),  16'(c));
    check({tag, " phase"},       16'(phase),       16'(p));
    check({tag, " active_road"}, 16'(active_road), 16'(r));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(ALLRED);
    rst = 1'b0;
  endtask

  task automatic add_vec(input logic [11:0] l, input int n, input logic [1:0] p,
                         input logic [1:0] r, input logic d, input logic f,
                         input logic [2:0] c);
    vec_t v;
    v.light = l; v.reps = n; v.phase = p; v.road = r;
    v.done = d; v.fault = f; v.code = c;
    tbl.push_back(v);
  endtask

  initial begin
    // Reset state
    step(ALLRED);
    step(ALLRED);
    check_out("reset", 1'b0, 3'd0, 2'd0, 2'd0);
    check("reset cycle_done", 16'(cycle_done), 16'd0);
    check("reset cycle_cnt", cycle_cnt, 16'd0);
    rst = 1'b0;

    // Two legal rotations with one all-red cycle between phases
    for (int rot = 0; rot < 2; rot++) begin
      for (int k = 0; k < 4; k++) begin
        add_vec(lv(k, LG), 20, 2'd1, 2'(k), 1'b0, 1'b0, 3'd0);
        add_vec(lv(k, LY), 5,  2'd2, 2'(k), 1'b0, 1'b0, 3'd0);
        add_vec(ALLRED,    1,  2'd3, 2'(k), k == 3, 1'b0, 3'd0);
      end
    end
    // Zero-gap handover road 0 -> 1, then road 1 yellow after only 19 greens
    add_vec(lv(0, LG), 20, 2'd1, 2'd0, 1'b0, 1'b0, 3'd0);
    add_vec(lv(0, LY), 5,  2'd2, 2'd0, 1'b0, 1'b0, 3'd0);
    add_vec(lv(1, LG), 19, 2'd1, 2'd1, 1'b0, 1'b0, 3'd0);
    add_vec(lv(1, LY), 1,  2'd1, 2'd1, 1'b0, 1'b1, 3'd4);
    add_vec(lv(1, LY), 3,  2'd1, 2'd1, 1'b0, 1'b1, 3'd4);
    add_vec(ALLRED,    2,  2'd1, 2'd1, 1'b0, 1'b1, 3'd4);

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        step(tbl[i].light);
        if (cycle_done) done_cnt++;
      end
      check_out($sformatf("row%0d", i), tbl[i].fault, tbl[i].code, tbl[i].phase, tbl[i].road);
      check($sformatf("row%0d cycle_done", i), 16'(cycle_done), 16'(tbl[i].done));
    end
    check("rotation done pulses", 16'(done_cnt), 16'd2);
    check("rotation cycle_cnt", cycle_cnt, ROT_EXP);

    // Reset out of a latched fault
    do_reset();
    check_out("reset mid-fault", 1'b0, 3'd0, 2'd0, 2'd0);

    // CONFLICT: road 0 green while road 2 yellow
    step(12'b100_010_100_001);
    check_out("conflict", 1'b1, 3'd2, 2'd0, 2'd0);

    // ENCODING wins over CONFLICT
    do_reset();
    step(12'b100_010_100_011);
    check_out("encoding", 1'b1, 3'd1, 2'd0, 2'd0);

    // SEQUENCE: road 2 green straight after road 0 yellow
    do_reset();
    steps(lv(0, LG), 3);
    steps(lv(0, LY), 5);
    check_out("seq pre", 1'b0, 3'd0, 2'd2, 2'd0);
    step(lv(2, LG));
    check_out("sequence", 1'b1, 3'd3, 2'd2, 2'd0);

    // STALL: three all-red cycles after road 3 yellow
    do_reset();
    steps(lv(3, LG), 2);
    steps(lv(3, LY), 5);
    step(ALLRED);
    check_out("allred 1", 1'b0, 3'd0, 2'd3, 2'd3);
    check("allred 1 cycle_done", 16'(cycle_done), 16'd1);
    check("allred 1 cycle_cnt", cycle_cnt, ONE_EXP);
    step(ALLRED);
    check_out("allred 2", 1'b0, 3'd0, 2'd3, 2'd3);
    check("allred 2 cycle_done", 16'(cycle_done), 16'd0);
    step(ALLRED);
    check_out("allred stall", 1'b1, 3'd6, 2'd3, 2'd3);

    // Reset mid-green of road 2, then resync on a green first seen at cycle 7
    do_reset();
    steps(lv(2, LG), 5);
    check_out("road2 green", 1'b0, 3'd0, 2'd1, 2'd2);
    do_reset();
    check_out("reset mid-green", 1'b0, 3'd0, 2'd0, 2'd0);
    steps(ALLRED, 6);
    check_out("resync wait", 1'b0, 3'd0, 2'd0, 2'd0);
    step(lv(1, LG));
    check_out("resync green", 1'b0, 3'd0, 2'd1, 2'd1);
    steps(lv(1, LG), 3);
    step(lv(1, LY));
    check_out("resync short green", 1'b0, 3'd0, 2'd2, 2'd1);

    // SYNC timeout: 64 cycles without green is fine, the 65th is not
    do_reset();
    steps(ALLRED, 64);
    check_out("sync 64", 1'b0, 3'd0, 2'd0, 2'd0);
    step(ALLRED);
    check_out("sync stall", 1'b1, 3'd6, 2'd0, 2'd0);

    // GREEN_TIME on overrun, applies even to the first phase
    do_reset();
    steps(lv(0, LG), 20);
    check_out("green 20", 1'b0, 3'd0, 2'd1, 2'd0);
    step(lv(0, LG));
    check_out("green overrun", 1'b1, 3'd4, 2'd1, 2'd0);

    // YELLOW_TIME on overrun
    do_reset();
    steps(lv(0, LG), 3);
    steps(lv(0, LY), 5);
    check_out("yellow 5", 1'b0, 3'd0, 2'd2, 2'd0);
    step(lv(0, LY));
    check_out("yellow overrun", 1'b1, 3'd5, 2'd2, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
